// File: rtl/core_exec_unit.sv
// ---------------------------------------------------------------------------
// core_exec_unit
//
// Fetch/execute slice of the 8051-style core: the 16-bit instruction
// register loaded byte-wise from ROM, the 8-bit accumulator ALU with its
// carry flag, and the 16-bit program counter that addresses the ROM.
// All strobes come from the control FSM; this block only registers state.
//
// Ports
//   clock          system clock, rising-edge
//   reset          asynchronous, active-low reset
//   rom_byte       byte read from ROM at rom_addr
//   ir_load_high   load rom_byte into ir[15:8] (opcode)
//   ir_load_low    load rom_byte into ir[7:0]  (operand / immediate)
//   alu_en         execute opcode in ir[15:8], register result and carry
//   acc            accumulator value (ALU operand 1)
//   dptr           data pointer for indirect jumps
//   pc_inc         PC <= PC + 1
//   pc_inc_offset  PC <= PC + sign-extended ir[7:0]
//   pc_set         PC <= {8'h00, ir[7:0]}
//   pc_jmp_ind     PC <= dptr + acc
//   int_a          interrupt acknowledge, PC <= 16'h0003
//   ir             instruction register
//   opcode         ir[15:8]
//   alu_result     registered ALU result, bit 8 = carry/borrow
//   carry          carry flag (PSW.CY)
//   rom_addr       program counter
// ---------------------------------------------------------------------------
module core_exec_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rom_byte,
    input  logic        ir_load_high,
    input  logic        ir_load_low,
    input  logic        alu_en,
    input  logic [7:0]  acc,
    input  logic [15:0] dptr,
    input  logic        pc_inc,
    input  logic        pc_inc_offset,
    input  logic        pc_set,
    input  logic        pc_jmp_ind,
    input  logic        int_a,
    output logic [15:0] ir,
    output logic [7:0]  opcode,
    output logic [8:0]  alu_result,
    output logic        carry,
    output logic [15:0] rom_addr
);

    localparam logic [7:0] OP_ADD  = 8'h24;
    localparam logic [7:0] OP_ADDC = 8'h34;
    localparam logic [7:0] OP_SUBB = 8'h94;
    localparam logic [7:0] OP_ORL  = 8'h44;
    localparam logic [7:0] OP_ANL  = 8'h54;
    localparam logic [7:0] OP_XRL  = 8'h64;
    localparam logic [7:0] OP_MOV  = 8'h74;
    localparam logic [7:0] OP_INC  = 8'h04;
    localparam logic [7:0] OP_DEC  = 8'h14;
    localparam logic [7:0] OP_CLR  = 8'hE4;
    localparam logic [7:0] OP_CPL  = 8'hF4;
    localparam logic [7:0] OP_RL   = 8'h23;
    localparam logic [7:0] OP_RR   = 8'h03;
    localparam logic [7:0] OP_CLRC = 8'hC3;
    localparam logic [7:0] OP_SETC = 8'hD3;

    logic [15:0] ir_reg;
    logic [8:0]  alu_result_reg;
    logic        carry_reg;
    logic [15:0] pc_reg;

    logic [8:0]  alu_next;
    logic        carry_next;
    logic [15:0] pc_next;
    logic [7:0]  imm;

    assign imm = ir_reg[7:0];

    // ALU: operates on the pre-edge IR, acc and carry. Only ADD/ADDC/SUBB
    // produce a bit-8 carry; CLR C / SETB C touch only the flag.
    always_comb begin
        alu_next   = {1'b0, acc};
        carry_next = carry_reg;
        unique case (ir_reg[15:8])
            OP_ADD: begin
                alu_next   = {1'b0, acc} + {1'b0, imm};
                carry_next = alu_next[8];
            end
            OP_ADDC: begin
                alu_next   = {1'b0, acc} + {1'b0, imm} + {8'h00, carry_reg};
                carry_next = alu_next[8];
            end
            OP_SUBB: begin
                // 9-bit wraparound makes bit 8 the borrow out.
                alu_next   = {1'b0, acc} - {1'b0, imm} - {8'h00, carry_reg};
                carry_next = alu_next[8];
            end
            OP_ORL:  alu_next = {1'b0, acc | imm};
            OP_ANL:  alu_next = {1'b0, acc & imm};
            OP_XRL:  alu_next = {1'b0, acc ^ imm};
            OP_MOV:  alu_next = {1'b0, imm};
            OP_INC:  alu_next = {1'b0, acc + 8'h01};
            OP_DEC:  alu_next = {1'b0, acc - 8'h01};
            OP_CLR:  alu_next = 9'h000;
            OP_CPL:  alu_next = {1'b0, ~acc};
            OP_RL:   alu_next = {1'b0, acc[6:0], acc[7]};
            OP_RR:   alu_next = {1'b0, acc[0], acc[7:1]};
            OP_CLRC: carry_next = 1'b0;
            OP_SETC: carry_next = 1'b1;
            default: alu_next = {1'b0, acc};
        endcase
    end

    // PC source select; the if-chain encodes the strobe priority.
    always_comb begin
        pc_next = pc_reg;
        if (int_a)
            pc_next = 16'h0003;
        else if (pc_set)
            pc_next = {8'h00, imm};
        else if (pc_jmp_ind)
            pc_next = dptr + {8'h00, acc};
        else if (pc_inc_offset)
            pc_next = pc_reg + {{8{imm[7]}}, imm};
        else if (pc_inc)
            pc_next = pc_reg + 16'h0001;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ir_reg         <= 16'h0000;
            alu_result_reg <= 9'h000;
            carry_reg      <= 1'b0;
            pc_reg         <= 16'h0000;
        end else begin
            if (ir_load_high)
                ir_reg[15:8] <= rom_byte;
            if (ir_load_low)
                ir_reg[7:0] <= rom_byte;
            if (alu_en) begin
                alu_result_reg <= alu_next;
                carry_reg      <= carry_next;
            end
            pc_reg <= pc_next;
        end
    end

    assign ir         = ir_reg;
    assign opcode     = ir_reg[15:8];
    assign alu_result = alu_result_reg;
    assign carry      = carry_reg;
    assign rom_addr   = pc_reg;

endmodule

// File: tb/tb_core_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_core_exec_unit
//
// Directed walk through the reset, ALU, PC and priority scenarios followed
// by randomized strobes, all compared against a behavioural model that
// tracks ir / result / carry / pc with plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_core_exec_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  rom_byte;
    logic        ir_load_high, ir_load_low, alu_en;
    logic [7:0]  acc;
    logic [15:0] dptr;
    logic        pc_inc, pc_inc_offset, pc_set, pc_jmp_ind, int_a;
    logic [15:0] ir;
    logic [7:0]  opcode;
    logic [8:0]  alu_result;
    logic        carry;
    logic [15:0] rom_addr;

    core_exec_unit dut (
        .clock         (clock),
        .reset         (reset),
        .rom_byte      (rom_byte),
        .ir_load_high  (ir_load_high),
        .ir_load_low   (ir_load_low),
        .alu_en        (alu_en),
        .acc           (acc),
        .dptr          (dptr),
        .pc_inc        (pc_inc),
        .pc_inc_offset (pc_inc_offset),
        .pc_set        (pc_set),
        .pc_jmp_ind    (pc_jmp_ind),
        .int_a         (int_a),
        .ir            (ir),
        .opcode        (opcode),
        .alu_result    (alu_result),
        .carry         (carry),
        .rom_addr      (rom_addr)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state
    logic [15:0] m_ir;
    logic [8:0]  m_res;
    logic        m_carry;
    logic [15:0] m_pc;

    logic [7:0] op_pool [16] = '{8'h24, 8'h34, 8'h94, 8'h44, 8'h54, 8'h64,
                                 8'h74, 8'h04, 8'h14, 8'hE4, 8'hF4, 8'h23,
                                 8'h03, 8'hC3, 8'hD3, 8'hA5};

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".ir"},         32'(ir),         32'(m_ir));
        check_eq({tag, ".opcode"},     32'(opcode),     32'(m_ir[15:8]));
        check_eq({tag, ".alu_result"}, 32'(alu_result), 32'(m_res));
        check_eq({tag, ".carry"},      32'(carry),      32'(m_carry));
        check_eq({tag, ".rom_addr"},   32'(rom_addr),   32'(m_pc));
    endtask

    // One rising edge of the reference behaviour, from pre-edge state.
    task automatic model_step();
        int a, im, c, s, off;
        logic [15:0] n_ir;
        if (!reset) begin
            m_ir = 0; m_res = 0; m_carry = 0; m_pc = 0;
            return;
        end
        a  = int'(acc);
        im = int'(m_ir[7:0]);
        c  = int'(m_carry);
        if (alu_en) begin
            case (m_ir[15:8])
                8'h24: begin s = a + im;     m_res = 9'(s); m_carry = (s > 255); end
                8'h34: begin s = a + im + c; m_res = 9'(s); m_carry = (s > 255); end
                8'h94: begin s = a - im - c; m_res = 9'(s); m_carry = (s < 0);   end
                8'h44: m_res = 9'(a | im);
                8'h54: m_res = 9'(a & im);
                8'h64: m_res = 9'(a ^ im);
                8'h74: m_res = 9'(im);
                8'h04: m_res = 9'((a + 1) % 256);
                8'h14: m_res = 9'((a + 255) % 256);
                8'hE4: m_res = 9'(0);
                8'hF4: m_res = 9'(255 - a);
                8'h23: m_res = 9'(((a * 2) % 256) + (a / 128));
                8'h03: m_res = 9'((a / 2) + ((a % 2) * 128));
                8'hC3: begin m_res = 9'(a); m_carry = 1'b0; end
                8'hD3: begin m_res = 9'(a); m_carry = 1'b1; end
                default: m_res = 9'(a);
            endcase
        end
        off = (im >= 128) ? im - 256 : im;
        if (int_a)              m_pc = 16'h0003;
        else if (pc_set)        m_pc = 16'(im);
        else if (pc_jmp_ind)    m_pc = 16'(int'(dptr) + a);
        else if (pc_inc_offset) m_pc = 16'(int'(m_pc) + off);
        else if (pc_inc)        m_pc = 16'(int'(m_pc) + 1);
        n_ir = m_ir;
        if (ir_load_high) n_ir[15:8] = rom_byte;
        if (ir_load_low)  n_ir[7:0]  = rom_byte;
        m_ir = n_ir;
    endtask

    task automatic clear_strobes();
        ir_load_high = 0; ir_load_low = 0; alu_en = 0;
        pc_inc = 0; pc_inc_offset = 0; pc_set = 0; pc_jmp_ind = 0; int_a = 0;
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clock);
        #1;
        check_all(tag);
        clear_strobes();
    endtask

    task automatic load_ir(input logic [7:0] hi, input logic [7:0] lo);
        ir_load_high = 1; rom_byte = hi; cycle("ld_hi");
        ir_load_low  = 1; rom_byte = lo; cycle("ld_lo");
    endtask

    initial begin
        clear_strobes();
        rom_byte = 8'h00; acc = 8'h00; dptr = 16'h0000;
        m_ir = 0; m_res = 0; m_carry = 0; m_pc = 0;
        reset = 0;
        #2;
        check_all("rst_init");
        // Strobes sampled while reset is low must be ignored.
        ir_load_high = 1; rom_byte = 8'hFF; pc_inc = 1; alu_en = 1; acc = 8'h77;
        cycle("rst_hold");
        reset = 1;

        // Build some state, then pulse reset between edges.
        ir_load_high = 1; rom_byte = 8'h24; pc_inc = 1; cycle("pre_pulse");
        #2 reset = 0;
        m_ir = 0; m_res = 0; m_carry = 0; m_pc = 0;
        #1;
        check_all("rst_pulse");
        #1 reset = 1;

        load_ir(8'h24, 8'h5A);
        check_eq("ir_245a", 32'(ir), 32'h245A);
        check_eq("opcode_24", 32'(opcode), 32'h24);

        acc = 8'hC0; alu_en = 1; cycle("add");
        check_eq("add_res", 32'(alu_result), 32'h11A);
        check_eq("add_cy", 32'(carry), 32'h1);

        load_ir(8'h34, 8'h01);
        acc = 8'h10; alu_en = 1; cycle("addc");
        check_eq("addc_res", 32'(alu_result), 32'h012);
        check_eq("addc_cy", 32'(carry), 32'h0);

        load_ir(8'h94, 8'h10);
        acc = 8'h05; alu_en = 1; cycle("subb");
        check_eq("subb_res", 32'(alu_result), 32'h1F5);
        check_eq("subb_cy", 32'(carry), 32'h1);

        load_ir(8'h74, 8'hAA);
        alu_en = 1; cycle("mov");
        check_eq("mov_res", 32'(alu_result), 32'h0AA);
        check_eq("mov_cy", 32'(carry), 32'h1);

        check_eq("pc_start", 32'(rom_addr), 32'h0000);
        pc_inc = 1; cycle("inc1");
        pc_inc = 1; cycle("inc2");
        check_eq("pc_2", 32'(rom_addr), 32'h0002);
        ir_load_low = 1; rom_byte = 8'hFE; cycle("ld_fe");
        pc_inc_offset = 1; cycle("off1");
        check_eq("pc_off_0", 32'(rom_addr), 32'h0000);
        pc_inc_offset = 1; cycle("off2");
        check_eq("pc_off_fffe", 32'(rom_addr), 32'hFFFE);
        pc_inc = 1; cycle("inc3");
        pc_inc = 1; cycle("inc4");
        check_eq("pc_wrap", 32'(rom_addr), 32'h0000);

        dptr = 16'h1000; acc = 8'h05; pc_jmp_ind = 1; cycle("jmp");
        check_eq("pc_jmp", 32'(rom_addr), 32'h1005);
        ir_load_low = 1; rom_byte = 8'h40; cycle("ld_40");
        pc_set = 1; pc_inc = 1; cycle("set");
        check_eq("pc_set", 32'(rom_addr), 32'h0040);

        int_a = 1; pc_set = 1; pc_inc = 1; cycle("int");
        check_eq("pc_int", 32'(rom_addr), 32'h0003);
        acc = 8'h3C; cycle("hold1");
        acc = 8'hC3; cycle("hold2");
        check_eq("alu_hold", 32'(alu_result), 32'h0AA);

        // Same-cycle IR load and execute uses the old opcode (MOV #0x40).
        ir_load_high = 1; rom_byte = 8'hE4; alu_en = 1; cycle("old_ir");
        check_eq("old_ir_res", 32'(alu_result), 32'h040);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            ir_load_high  = ($urandom_range(0, 3) == 0);
            ir_load_low   = ($urandom_range(0, 3) == 0);
            rom_byte      = ir_load_high && ($urandom_range(0, 4) != 0)
                            ? op_pool[$urandom_range(0, 15)] : 8'($urandom);
            alu_en        = ($urandom_range(0, 1) == 1);
            acc           = 8'($urandom);
            dptr          = 16'($urandom);
            pc_inc        = ($urandom_range(0, 1) == 1);
            pc_inc_offset = ($urandom_range(0, 3) == 0);
            pc_set        = ($urandom_range(0, 7) == 0);
            pc_jmp_ind    = ($urandom_range(0, 7) == 0);
            int_a         = ($urandom_range(0, 15) == 0);
            cycle("rnd");
        end

        // Reset asserted mid-operation with strobes active.
        ir_load_high = 1; rom_byte = 8'h55; alu_en = 1; pc_inc = 1;
        #2 reset = 0;
        m_ir = 0; m_res = 0; m_carry = 0; m_pc = 0;
        #1;
        check_all("rst_mid");
        cycle("rst_mid_edge");
        reset = 1;
        pc_inc = 1; cycle("post_rst");
        check_eq("post_rst_pc", 32'(rom_addr), 32'h0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/core_exec_unit.md
# core_exec_unit

Instruction-fetch and execute slice of the 8051-style core: a 16-bit instruction register fed byte-wise from ROM, an 8-bit accumulator ALU with a carry flag, and the 16-bit program counter that drives the ROM address. It sits between the control FSM, which supplies all strobes, and the accumulator/DPTR registers, which it reads. All state is registered on one clock.

## Interface
- No parameters.
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- rom_byte  in  8  byte read from ROM at rom_addr.
- ir_load_high  in  1  load rom_byte into ir[15:8] (opcode).
- ir_load_low  in  1  load rom_byte into ir[7:0] (operand).
- alu_en  in  1  execute the opcode in ir[15:8] and register the result.
- acc  in  8  current accumulator value (operand 1).
- dptr  in  16  data pointer, used for indirect jumps.
- pc_inc  in  1  PC <= PC+1.
- pc_inc_offset  in  1  PC <= PC + sign-extended ir[7:0].
- pc_set  in  1  PC <= {8'h00, ir[7:0]}.
- pc_jmp_ind  in  1  PC <= dptr + {8'h00, acc}.
- int_a  in  1  interrupt acknowledge: PC <= 16'h0003.
- ir  out  16  instruction register.
- opcode  out  8  equals ir[15:8].
- alu_result  out  9  registered ALU result; bit 8 is carry/borrow.
- carry  out  1  carry flag (PSW.CY).
- rom_addr  out  16  program counter value.

## Operation
- IR: each half loads independently; both strobes in one cycle load the same byte into both halves. No strobe: hold.
- ALU: with alu_en=1, alu_result and, where stated, carry update from acc, imm=ir[7:0], and the current carry. With alu_en=0, both hold.
- Arithmetic uses 9-bit unsigned sums; results wrap mod 256 in bits 7:0.
  - 0x24 ADD: {0,acc}+{0,imm}; carry <= bit 8.
  - 0x34 ADDC: acc+imm+carry; carry <= bit 8.
  - 0x94 SUBB: {0,acc}-{0,imm}-carry; bit 8 is the borrow; carry <= bit 8.
  - 0x44 ORL: acc|imm.
  - 0x54 ANL: acc&imm.
  - 0x64 XRL: acc^imm.
  - 0x74 MOV #imm: imm.
  - 0x04 INC: acc+1.
  - 0x14 DEC: acc-1.
  - 0xE4 CLR: 0.
  - 0xF4 CPL: ~acc.
  - 0x23 RL: {acc[6:0],acc[7]}.
  - 0x03 RR: {acc[0],acc[7:1]}.
  - 0xC3 CLR C: carry <= 0; result = {0,acc}.
  - 0xD3 SETB C: carry <= 1; result = {0,acc}.
  - Any other opcode: {0,acc}.
- For every non-arithmetic opcode, bit 8 of alu_result is 0 and carry is unchanged (except CLR C / SETB C, as listed).
- PC priority when several strobes are active, highest first: int_a > pc_set > pc_jmp_ind > pc_inc_offset > pc_inc. No strobe: hold.
- PC arithmetic is mod 2^16: 16'hFFFF+1 = 16'h0000. Offset 0x80..0xFF is negative, e.g. 0xFE = -2.

## Timing
- Reset low, asynchronously: ir=0, alu_result=0, carry=0, rom_addr=0. Outputs stay at these values while reset is low.
- Reset asserted mid-operation discards any in-progress load or update.
- Strobes take effect on the first rising edge after reset deasserts.
- Each strobe has one-cycle latency: the effect is visible on the outputs after the edge it is sampled on.
- The ALU and PC use pre-edge values of ir, acc and carry. A same-cycle ir_load and alu_en therefore executes the old IR.
- opcode is combinational from ir.
- No handshakes. Strobes are level-sampled each cycle; holding one for N cycles applies it N times (e.g., pc_inc held 3 cycles adds 3).

## Test plan
- Reset: drive values, pulse reset low between edges -> all outputs 0 immediately. Release, pulse ir_load_high (rom_byte 0x24), then ir_load_low (0x5A) -> ir=0x245A, opcode=0x24.
- ADD/ADDC: ir=0x245A, acc=0xC0, alu_en -> alu_result=0x11A, carry=1. Then ir=0x3401, acc=0x10 -> 0x012, carry=0.
- SUBB borrow: carry=0, ir=0x9410, acc=0x05 -> alu_result=0x1F5, carry=1. Then ir=0x74AA -> 0x0AA, carry stays 1.
- PC: from 0x0000, pc_inc 2 cycles -> 0x0002. ir[7:0]=0xFE, pc_inc_offset -> 0x0000. Again -> 0xFFFE. pc_inc twice -> 0x0000 (wrap).
- Indirect and set: dptr=0x1000, acc=0x05, pc_jmp_ind -> 0x1005. ir[7:0]=0x40, pc_set together with pc_inc -> 0x0040.
- Interrupt priority: int_a together with pc_set and pc_inc -> rom_addr=0x0003. alu_en=0 with a changing acc -> alu_result holds.
